// File: rtl/mult_pkg.sv
// Shared types and defaults for the iterative multiply/stall unit.
package mult_pkg;
   typedef enum logic [1:0] {
      MS_IDLE = 2'd0,
      MS_BUSY = 2'd1,
      MS_DONE = 2'd2
   } mult_state_e;

   localparam int MULT_CYCLES = 4;

   // A single-iteration configuration still needs a one-bit counter.
   function automatic int cnt_width(input int cycles);
      return (cycles > 1) ? $clog2(cycles) : 1;
   endfunction

   localparam int MULT_CNT_W = cnt_width(MULT_CYCLES);
endpackage

// File: rtl/mult_step.sv
// One shift-add iteration: adds multiplicand * multiplier slice, weighted by the
// iteration index, into the accumulator. Purely combinational.
module mult_step #(
   parameter int DATA_W = 32,
   parameter int ACC_W  = 32,
   parameter int STEP_W = 8,
   parameter int CNT_W  = 2
) (
   input  logic [ACC_W-1:0]  acc_i,
   input  logic [DATA_W-1:0] mcand_i,
   input  logic [STEP_W-1:0] slice_i,
   input  logic [CNT_W-1:0]  cnt_i,
   output logic [ACC_W-1:0]  acc_o
);
   typedef logic [ACC_W-1:0] acc_t;

   acc_t partial;
   int   shamt;

   // Partial product is computed at accumulator width so carries past ACC_W drop out.
   always_comb begin
      partial = acc_t'(mcand_i) * acc_t'(slice_i);
      shamt   = int'(cnt_i) * STEP_W;
      acc_o   = acc_i + (partial << shamt);
   end
endmodule

// File: rtl/mult_stall_unit.sv
// EX-stage iterative multiplier and sole source of the pipeline global_enable.
// Optional MULT_HIGH_EN: double-width accumulator and high_sel for the upper half.
module mult_stall_unit
   import mult_pkg::*;
#(
   parameter int DATA_W = 32,
   parameter int CYCLES = MULT_CYCLES
) (
   input  logic              clk,
   input  logic              arst,
   input  logic              ext_enable,
   input  logic              start,
   input  logic [DATA_W-1:0] op_a,
   input  logic [DATA_W-1:0] op_b,
`ifdef MULT_HIGH_EN
   input  logic              high_sel,
`endif
   output logic              global_enable,
   output logic [DATA_W-1:0] result,
   output logic              result_valid,
   output logic              busy
);
   localparam int STEP_W = DATA_W / CYCLES;
   localparam int CNT_W  = cnt_width(CYCLES);
`ifdef MULT_HIGH_EN
   localparam int ACC_W  = 2 * DATA_W;
`else
   localparam int ACC_W  = DATA_W;
`endif
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CYCLES - 1);

   mult_state_e       state_q, state_d;
   logic [ACC_W-1:0]  acc_q, acc_d, acc_step;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [DATA_W-1:0] op_a_q, op_a_d;
   logic [DATA_W-1:0] op_b_q, op_b_d;
   logic [DATA_W-1:0] result_q, result_d;
   logic              result_valid_q, result_valid_d;
   logic [DATA_W-1:0] final_word;
`ifdef MULT_HIGH_EN
   logic              high_sel_q, high_sel_d;
`endif

   mult_step #(
      .DATA_W (DATA_W),
      .ACC_W  (ACC_W),
      .STEP_W (STEP_W),
      .CNT_W  (CNT_W)
   ) u_step (
      .acc_i   (acc_q),
      .mcand_i (op_a_q),
      .slice_i (op_b_q[STEP_W-1:0]),
      .cnt_i   (cnt_q),
      .acc_o   (acc_step)
   );

   // Word captured into result on the last iteration.
   always_comb begin
`ifdef MULT_HIGH_EN
      final_word = high_sel_q ? acc_step[ACC_W-1:DATA_W] : acc_step[DATA_W-1:0];
`else
      final_word = acc_step;
`endif
   end

   always_comb begin
      state_d        = state_q;
      acc_d          = acc_q;
      cnt_d          = cnt_q;
      op_a_d         = op_a_q;
      op_b_d         = op_b_q;
      result_d       = result_q;
      result_valid_d = result_valid_q;
      global_enable  = 1'b0;
`ifdef MULT_HIGH_EN
      high_sel_d     = high_sel_q;
`endif
      unique case (state_q)
         MS_IDLE: begin
            // The multiply in EX must hold the pipeline already in its issue cycle.
            global_enable  = ext_enable & ~start;
            result_valid_d = 1'b0;
            if (start) begin
               op_a_d  = op_a;
               op_b_d  = op_b;
               acc_d   = '0;
               cnt_d   = '0;
`ifdef MULT_HIGH_EN
               high_sel_d = high_sel;
`endif
               state_d = MS_BUSY;
            end
         end
         MS_BUSY: begin
            acc_d  = acc_step;
            op_b_d = op_b_q >> STEP_W;
            cnt_d  = cnt_q + 1'b1;
            if (cnt_q == CNT_LAST) begin
               result_d       = final_word;
               result_valid_d = 1'b1;
               state_d        = MS_DONE;
            end
         end
         MS_DONE: begin
            // start is the same instruction still sitting in EX, so it is not re-accepted here.
            global_enable = ext_enable;
            if (ext_enable) begin
               result_valid_d = 1'b0;
               state_d        = MS_IDLE;
            end
         end
         default: begin
            result_valid_d = 1'b0;
            state_d        = MS_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or posedge arst) begin
      if (arst) begin
         state_q        <= MS_IDLE;
         acc_q          <= '0;
         cnt_q          <= '0;
         op_a_q         <= '0;
         op_b_q         <= '0;
         result_q       <= '0;
         result_valid_q <= 1'b0;
`ifdef MULT_HIGH_EN
         high_sel_q     <= 1'b0;
`endif
      end else begin
         state_q        <= state_d;
         acc_q          <= acc_d;
         cnt_q          <= cnt_d;
         op_a_q         <= op_a_d;
         op_b_q         <= op_b_d;
         result_q       <= result_d;
         result_valid_q <= result_valid_d;
`ifdef MULT_HIGH_EN
         high_sel_q     <= high_sel_d;
`endif
      end
   end

   assign busy         = (state_q != MS_IDLE);
   assign result       = result_q;
   assign result_valid = result_valid_q;
endmodule

// File: tb/tb_mult_stall_unit.sv
// Scoreboard bench for mult_stall_unit: driver pushes reference products, a
// negedge monitor compares whenever result_valid is presented.
module tb_mult_stall_unit;
   localparam int DATA_W = 32;
   localparam int CYCLES = 4;

   logic              clk = 1'b0;
   logic              arst;
   logic              ext_enable;
   logic              start;
   logic [DATA_W-1:0] op_a;
   logic [DATA_W-1:0] op_b;
   logic              high_sel;
   logic              global_enable;
   logic [DATA_W-1:0] result;
   logic              result_valid;
   logic              busy;

   int total = 0;
   int bad   = 0;
   logic [DATA_W-1:0] exp_q[$];

   mult_stall_unit #(.DATA_W(DATA_W), .CYCLES(CYCLES)) dut (
      .clk           (clk),
      .arst          (arst),
      .ext_enable    (ext_enable),
      .start         (start),
      .op_a          (op_a),
      .op_b          (op_b),
`ifdef MULT_HIGH_EN
      .high_sel      (high_sel),
`endif
      .global_enable (global_enable),
      .result        (result),
      .result_valid  (result_valid),
      .busy          (busy)
   );

   always #5 clk = ~clk;

   // Reference: full 64-bit unsigned product, then pick the requested word.
   function automatic logic [DATA_W-1:0] ref_mul(input logic [DATA_W-1:0] a,
                                                 input logic [DATA_W-1:0] b,
                                                 input logic hs);
      logic [2*DATA_W-1:0] p;
      p = {{DATA_W{1'b0}}, a} * {{DATA_W{1'b0}}, b};
`ifdef MULT_HIGH_EN
      return hs ? p[2*DATA_W-1:DATA_W] : p[DATA_W-1:0];
`else
      return (hs & 1'b0) ? '0 : p[DATA_W-1:0];
`endif
   endfunction

   task automatic chk(input string name, input logic [DATA_W-1:0] got,
                      input logic [DATA_W-1:0] want);
      total++;
      if (got !== want) begin
         bad++;
         $display("FAIL %s got=%h required=%h t=%0t", name, got, want, $time);
      end
   endtask

   // Monitor: every cycle result_valid is seen, result must equal the head of
   // the scoreboard; the entry retires on the cycle the pipeline captures it.
   always @(negedge clk) begin
      if (!arst && result_valid) begin
         total++;
         if (exp_q.size() == 0) begin
            bad++;
            $display("FAIL spurious_valid got result=%h required no result_valid t=%0t", result, $time);
         end else begin
            if (result !== exp_q[0]) begin
               bad++;
               $display("FAIL result got=%h required=%h t=%0t", result, exp_q[0], $time);
            end
            if (ext_enable) void'(exp_q.pop_front());
         end
      end
   end

   // Called just after a posedge with the DUT in IDLE; returns likewise.
   task automatic do_mult(input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] b,
                          input logic hs, input int stall);
      start = 1'b1; op_a = a; op_b = b; high_sel = hs; ext_enable = 1'b1;
      exp_q.push_back(ref_mul(a, b, hs));
      @(negedge clk);
      chk("ge_start", {31'd0, global_enable}, 32'd0);
      chk("busy_idle", {31'd0, busy}, 32'd0);
      @(posedge clk); #1;
      start = 1'b0; op_a = $urandom; op_b = $urandom; high_sel = 1'($urandom);
      for (int k = 0; k < CYCLES; k++) begin
         ext_enable = 1'($urandom);
         @(negedge clk);
         chk("busy_busy", {31'd0, busy}, 32'd1);
         chk("ge_busy", {31'd0, global_enable}, 32'd0);
         chk("rv_busy", {31'd0, result_valid}, 32'd0);
         @(posedge clk); #1;
      end
      for (int k = 0; k <= stall; k++) begin
         ext_enable = (k == stall);
         start = 1'($urandom);
         @(negedge clk);
         chk("rv_done", {31'd0, result_valid}, 32'd1);
         chk("ge_done", {31'd0, global_enable}, {31'd0, ext_enable});
         @(posedge clk); #1;
      end
      start = 1'b0; ext_enable = 1'b1;
   endtask

   initial begin
      logic [DATA_W-1:0] ra, rb;
      arst = 1'b1; start = 1'b1; ext_enable = 1'b1;
      op_a = '0; op_b = '0; high_sel = 1'b0;
      repeat (2) @(negedge clk);
      chk("rst_ge_start", {31'd0, global_enable}, 32'd0);
      chk("rst_busy", {31'd0, busy}, 32'd0);
      chk("rst_result", result, 32'd0);
      chk("rst_rv", {31'd0, result_valid}, 32'd0);
      start = 1'b0; #1;
      chk("rst_ge_idle", {31'd0, global_enable}, 32'd1);
      @(posedge clk); #1;
      arst = 1'b0;
      @(posedge clk); #1;

      do_mult(32'd7, 32'd6, 1'b0, 0);
      @(negedge clk);
      chk("idle_after_done", {31'd0, busy}, 32'd0);
      @(posedge clk); #1;
      do_mult(32'hFFFF_FFFF, 32'd2, 1'b0, 0);
`ifdef MULT_HIGH_EN
      do_mult(32'hFFFF_FFFF, 32'd2, 1'b1, 0);
`endif
      do_mult(32'h1234_5678, 32'h9ABC_DEF0, 1'b0, 3);
      do_mult(32'd3, 32'd5, 1'b0, 0);

      // Reset in the middle of an iteration: nothing may be presented afterwards.
      start = 1'b1; op_a = 32'd11; op_b = 32'd13; ext_enable = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (2) begin @(posedge clk); #1; end
      arst = 1'b1;
      @(negedge clk);
      chk("mid_rst_busy", {31'd0, busy}, 32'd0);
      chk("mid_rst_rv", {31'd0, result_valid}, 32'd0);
      chk("mid_rst_result", result, 32'd0);
      chk("mid_rst_ge", {31'd0, global_enable}, 32'd1);
      @(posedge clk); #1;
      arst = 1'b0;
      repeat (6) begin
         @(negedge clk);
         chk("post_rst_idle", {31'd0, busy}, 32'd0);
         @(posedge clk); #1;
      end
      do_mult(32'd100, 32'd200, 1'b0, 1);

      for (int n = 0; n < 40; n++) begin
         ra = $urandom; rb = $urandom;
         if (n % 8 == 0) ra = '1;
         if (n % 8 == 1) rb = '0;
         do_mult(ra, rb, 1'($urandom), int'($urandom_range(0, 3)));
         if ($urandom_range(0, 9) < 3) begin
            ext_enable = 1'($urandom);
            @(negedge clk);
            chk("gap_ge", {31'd0, global_enable}, {31'd0, ext_enable});
            chk("gap_busy", {31'd0, busy}, 32'd0);
            chk("gap_rv", {31'd0, result_valid}, 32'd0);
            @(posedge clk); #1;
            ext_enable = 1'b1;
         end
      end

      repeat (3) @(posedge clk);
      chk("queue_drained", 32'(exp_q.size()), 32'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
